regfile_writeback: RTL and testbench

- Producer side of the register file's write port: merges the ALU result stream and the load-return stream into the single write interface (write, reg_write, wdata).
- Buffers load returns in a small FIFO and extracts and sign-extends byte/half loads.
- Arbitrates one write per cycle, with ALU priority and a starvation guard for loads.
- Exports a pending-destination mask so the decode stage can stall on an outstanding load.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/regfile_writeback_if.sv | 33 +++
 rtl/wb_load_fifo.sv | 57 +++++
 rtl/regfile_writeback.sv | 126 ++++++++++++
 tb/tb_regfile_writeback.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the register-file writeback path.
package mips_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ld_size_e;

  typedef enum logic {
    ALU_PRI = 1'b0,
    LD_PRI  = 1'b1
  } arb_state_e;

  // Raw load-return fields; size keeps the reserved encoding 3 intact.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     word;
    logic [1:0]            addr_lo;
    logic [1:0]            size;
    logic                  sgn;
  } ld_entry_t;

  function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return addr_lo[0];
    return addr_lo != 2'b00;
  endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// ALU result stream, load-return stream and register-file write port.
interface regfile_writeback_if;
  import mips_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0]     alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0]     ld_word;
  logic [1:0]            ld_addr_lo;
  logic [1:0]            ld_size;
  logic                  ld_signed;
  logic                  write;
  logic [REG_ADDR_W-1:0] reg_write;
  logic [DATA_W-1:0]     wdata;
  logic [31:0]           pending;
  logic                  misalign;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ld_valid, ld_dest, ld_word, ld_addr_lo, ld_size, ld_signed,
    input  alu_ready, ld_ready, write, reg_write, wdata, pending, misalign
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ld_valid, ld_dest, ld_word, ld_addr_lo, ld_size, ld_signed,
    output alu_ready, ld_ready, write, reg_write, wdata, pending, misalign
  );
endinterface

// File: rtl/wb_load_fifo.sv
// Load-return FIFO storing raw fields; exposes per-entry valid/dest for hazard tracking.
module wb_load_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  ld_entry_t                       push_data,
  input  logic                            pop,
  output logic                            full,
  output logic                            empty,
  output ld_entry_t                       head,
  output logic [DEPTH-1:0]                ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dest
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ld_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] off;

  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    off       = '0;
    ent_valid = '0;
    ent_dest  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr;
      ent_valid[i] = {1'b0, off} < count;
      ent_dest[i]  = mem[i].dest;
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU results and load returns into the single register-file write port.
module regfile_writeback
  import mips_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic                clk,
  input logic                reset,
  regfile_writeback_if.slave bus
);
  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  arb_state_e                        state;
  arb_state_e                        state_next;
  logic [WAIT_W-1:0]                 wait_cnt;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic                              push;
  logic                              pop;
  logic                              alu_take;
  logic                              ld_turn;
  logic                              head_mis;
  ld_entry_t                         head;
  ld_entry_t                         push_entry;
  logic [LD_DEPTH-1:0]               ent_valid;
  logic [LD_DEPTH-1:0][REG_ADDR_W-1:0] ent_dest;
  logic [31:0]                       pend;
  logic                              write_q;
  logic [REG_ADDR_W-1:0]             reg_write_q;
  logic [DATA_W-1:0]                 wdata_q;
  logic                              misalign_q;

  function automatic logic [DATA_W-1:0] extract(input ld_entry_t e);
    logic [7:0]  b;
    logic [15:0] h;
    b = e.word[{e.addr_lo, 3'b000} +: 8];
    h = e.addr_lo[1] ? e.word[31:16] : e.word[15:0];
    if (e.size == SZ_BYTE) return e.sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
    if (e.size == SZ_HALF) return e.sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
    return e.word;
  endfunction

  assign push_entry = '{dest: bus.ld_dest, word: bus.ld_word, addr_lo: bus.ld_addr_lo,
                        size: bus.ld_size, sgn: bus.ld_signed};
  assign push        = bus.ld_valid && !fifo_full;
  assign bus.ld_ready = !fifo_full;

  wb_load_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head),
    .ent_valid(ent_valid),
    .ent_dest (ent_dest)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ALU_PRI;
    else       state <= state_next;
  end

  // LD_PRI with an empty FIFO degenerates to ALU priority for that cycle.
  always_comb begin
    state_next = ALU_PRI;
    ld_turn    = 1'b0;
    case (state)
      ALU_PRI: state_next = (wait_cnt == WAIT_W'(MAX_WAIT)) ? LD_PRI : ALU_PRI;
      LD_PRI: begin
        state_next = ALU_PRI;
        ld_turn    = !fifo_empty;
      end
      default: state_next = ALU_PRI;
    endcase
    alu_take = bus.alu_valid && !ld_turn;
    pop      = !fifo_empty && !alu_take;
  end

  assign bus.alu_ready = !ld_turn;
  assign head_mis      = ld_misaligned(head.size, head.addr_lo);

  always_ff @(posedge clk) begin
    if (reset || fifo_empty || pop)         wait_cnt <= '0;
    else if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q     <= 1'b0;
      reg_write_q <= '0;
      wdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else if (alu_take) begin
      write_q     <= bus.alu_dest != '0;
      reg_write_q <= bus.alu_dest;
      wdata_q     <= bus.alu_data;
      misalign_q  <= 1'b0;
    end else if (pop) begin
      write_q     <= (head.dest != '0) && !head_mis;
      reg_write_q <= head.dest;
      wdata_q     <= extract(head);
      misalign_q  <= head_mis;
    end else begin
      write_q    <= 1'b0;
      misalign_q <= 1'b0;
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      if (ent_valid[i]) pend[ent_dest[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign bus.pending   = pend;
  assign bus.write     = write_q;
  assign bus.reg_write = reg_write_q;
  assign bus.wdata     = wdata_q;
  assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
  import mips_pkg::*;

  localparam int unsigned LD_DEPTH = 2;
  localparam int unsigned MAX_WAIT = 4;

  typedef struct {
    int unsigned dest;
    int unsigned word;
    int unsigned lo;
    int unsigned size;
    bit          sgn;
  } mload_t;

  typedef struct {
    int          cyc;
    bit          wr;
    bit          mis;
    int unsigned dest;
    int unsigned data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_if bus();

  regfile_writeback #(.LD_DEPTH(LD_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  mload_t      mq[$];
  exp_t        sb[$];
  int unsigned m_wait = 0;
  bit          m_ldpri = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned ref_value(input mload_t l);
    int unsigned v;
    if (l.size == 0) begin
      v = (l.word >> (8 * l.lo)) % 256;
      if (l.sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (l.size == 1) begin
      v = (l.word >> (16 * (l.lo / 2))) % 65536;
      if (l.sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = l.word;
    end
    return v;
  endfunction

  function automatic bit ref_mis(input mload_t l);
    if (l.size == 1) return (l.lo % 2) == 1;
    if (l.size >= 2) return l.lo != 0;
    return 1'b0;
  endfunction

  function automatic longint ref_pending();
    longint m = 0;
    foreach (mq[i]) if (mq[i].dest != 0) m = m | (longint'(1) << mq[i].dest);
    return m;
  endfunction

  function automatic mload_t rand_load();
    mload_t l;
    l.dest = $urandom_range(31);
    l.word = $urandom;
    l.lo   = $urandom_range(3);
    l.size = $urandom_range(3);
    l.sgn  = 1'($urandom_range(1));
    return l;
  endfunction

  // Drive one cycle at the falling edge, predict this cycle's handshake and
  // the output expected after the next rising edge.
  task automatic step(input bit rst, input bit av, input int unsigned ad, input int unsigned adata,
                      input bit lv, input mload_t l);
    bit     ld_turn, pop, nonempty, next_ldpri;
    int     sz;
    mload_t h;
    reset          = rst;
    bus.alu_valid  = av;
    bus.alu_dest   = 5'(ad);
    bus.alu_data   = adata;
    bus.ld_valid   = lv;
    bus.ld_dest    = 5'(l.dest);
    bus.ld_word    = l.word;
    bus.ld_addr_lo = 2'(l.lo);
    bus.ld_size    = 2'(l.size);
    bus.ld_signed  = l.sgn;
    #1;
    if (rst) begin
      mq.delete();
      m_wait  = 0;
      m_ldpri = 1'b0;
    end else begin
      sz       = mq.size();
      nonempty = sz > 0;
      ld_turn  = m_ldpri && nonempty;
      check("alu_ready", bus.alu_ready, !ld_turn);
      check("ld_ready", bus.ld_ready, sz < LD_DEPTH);
      check("pending", bus.pending, ref_pending());
      pop = 1'b0;
      if (av && !ld_turn) begin
        if (ad != 0) sb.push_back('{cyc + 1, 1'b1, 1'b0, ad, adata});
      end else if (nonempty) begin
        h   = mq.pop_front();
        pop = 1'b1;
        if (ref_mis(h))       sb.push_back('{cyc + 1, 1'b0, 1'b1, h.dest, 0});
        else if (h.dest != 0) sb.push_back('{cyc + 1, 1'b1, 1'b0, h.dest, ref_value(h)});
      end
      if (lv && sz < LD_DEPTH) mq.push_back(l);
      next_ldpri = !m_ldpri && (m_wait == MAX_WAIT);
      if (!nonempty || pop)       m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      m_ldpri = next_ldpri;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    mload_t z = '{0, 0, 0, 0, 1'b0};
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, z);
  endtask

  // Monitor: every presented write or misalign pulse must match the oldest expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #2;
      if (bus.write === 1'b1 || bus.misalign === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {bus.write, bus.misalign}, 0);
        end else begin
          e = sb.pop_front();
          check("out_cycle", cyc, e.cyc);
          check("write", bus.write, e.wr);
          check("misalign", bus.misalign, e.mis);
          if (e.wr) begin
            check("reg_write", bus.reg_write, e.dest);
            check("wdata", bus.wdata, e.data);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        check("missing_output", cyc, sb[0].cyc - 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    mload_t z = '{0, 0, 0, 0, 1'b0};
    mload_t l;
    @(negedge clk);
    step(1'b1, 1'b0, 0, 0, 1'b0, z);
    step(1'b1, 1'b0, 0, 0, 1'b0, z);
    check("rst_write", bus.write, 0);
    check("rst_reg_write", bus.reg_write, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_misalign", bus.misalign, 0);
    check("rst_pending", bus.pending, 0);

    step(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, z);
    check("alu_wdata", bus.wdata, 32'hDEAD_BEEF);
    idle(1);
    check("alu_write_drop", bus.write, 0);

    step(1'b0, 1'b0, 0, 0, 1'b1, '{7, 32'h80FF_7F01, 3, 0, 1'b1});
    idle(1);
    check("byte_sext", bus.wdata, 32'hFFFF_FF80);
    step(1'b0, 1'b0, 0, 0, 1'b1, '{8, 32'h80FF_7F01, 2, 1, 1'b0});
    idle(1);
    check("half_zext", bus.wdata, 32'h0000_80FF);

    // Starvation guard with ALU busy every cycle.
    step(1'b0, 1'b1, 3, $urandom, 1'b1, '{9, 32'h1234_5678, 0, 2, 1'b0});
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1 + $urandom_range(30), $urandom, 1'b0, z);

    // Three loads against a two-entry FIFO while the ALU stays busy.
    for (int i = 0; i < 3; i++) begin
      l = '{10 + i, 32'h1111_0000 + i, 0, 2, 1'b0};
      step(1'b0, 1'b1, 20, $urandom, 1'b1, l);
      while (!bus.ld_ready) step(1'b0, 1'b1, 20, $urandom, 1'b0, z);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 21, $urandom, 1'b0, z);

    step(1'b0, 1'b0, 0, 0, 1'b1, '{12, 32'hAAAA_BBBB, 1, 1, 1'b1});
    idle(1);
    check("misalign_half", bus.misalign, 1);
    step(1'b0, 1'b0, 0, 0, 1'b1, '{13, 32'hAAAA_BBBB, 2, 2, 1'b0});
    idle(1);
    check("misalign_word", bus.misalign, 1);
    step(1'b0, 1'b1, 0, 32'hCAFE_0000, 1'b0, z);
    check("dest0_write", bus.write, 0);
    check("dest0_wdata", bus.wdata, 32'hCAFE_0000);

    // Reset with loads queued.
    step(1'b0, 1'b1, 4, 1, 1'b1, '{14, 5, 0, 2, 1'b0});
    step(1'b0, 1'b1, 4, 2, 1'b1, '{15, 6, 0, 2, 1'b0});
    step(1'b1, 1'b0, 0, 0, 1'b0, z);
    check("post_rst_pending", bus.pending, 0);
    check("post_rst_write", bus.write, 0);
    idle(6);

    for (int i = 0; i < 500; i++) begin
      step(1'b0, $urandom_range(99) < (i < 250 ? 60 : 95), $urandom_range(31), $urandom,
           $urandom_range(1), rand_load());
    end
    idle(12);
    check("scoreboard_empty", sb.size(), 0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
